// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared definitions for the instruction-fetch front end: predecode opcodes,
// the NOP word, the fetch FSM state type and the default address width.
// Imported by fetch_ctrl and fetch_predecode (and reusable by stage-2 control).
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

  // Default PC / instruction-memory address width
  localparam int ADDR_W_DEF = 12;

  // Opcode field is instr[31:27]
  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_JAL = 5'b00011;
  localparam logic [4:0] OP_JR  = 5'b00100;

  // Bubble word inserted on IR_Stage1
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Fetch FSM states
  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_WAIT_JR = 2'd2
  } fetch_state_e;

  // Extract the opcode field of an instruction word
  function automatic logic [4:0] opcode_of(input logic [31:0] instr);
    return instr[31:27];
  endfunction

endpackage

// File: rtl/fetch_ctrl_predecode.sv
// -----------------------------------------------------------------------------
// fetch_predecode
// Purely combinational predecode of a fetched word, so the fetch unit can steer
// the PC in the same cycle the word arrives.
// Ports:
//   instr_i   in  32      fetched instruction word
//   is_j_o    out 1       word is J or JAL (unconditional direct jump)
//   is_jr_o   out 1       word is JR (target known only downstream)
//   target_o  out ADDR_W  direct jump target, instr_i[ADDR_W-1:0]
// -----------------------------------------------------------------------------
module fetch_predecode
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [31:0]       instr_i,
  output logic              is_j_o,
  output logic              is_jr_o,
  output logic [ADDR_W-1:0] target_o
);

  // Only the opcode and low target bits matter here; fold the rest away
  logic unused_instr_s;
  assign unused_instr_s = ^instr_i;

  // Classify the word by opcode; J and JAL redirect the fetch identically
  always_comb begin
    is_j_o   = 1'b0;
    is_jr_o  = 1'b0;
    target_o = instr_i[ADDR_W-1:0];
    case (opcode_of(instr_i))
      OP_J, OP_JAL: begin
        is_j_o = 1'b1;
      end
      OP_JR: begin
        is_jr_o = 1'b1;
      end
      default: begin
        is_j_o  = 1'b0;
        is_jr_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch controller for the front of the 5-stage pipeline. Owns the
// PC, drives the instruction-memory address and produces the stage-1
// instruction register. Direct jumps are followed with no bubble; behind a JR
// the fetch parks in WAIT_JR issuing NOPs until a downstream redirect arrives.
// Ports:
//   clock           in  1       rising-edge clock
//   reset           in  1       synchronous, active-high
//   imem_addr       out ADDR_W  fetch address (the PC register)
//   imem_data       in  32      word at imem_addr, valid in the same cycle
//   stall           in  1       downstream hazard: hold PC/IR/count/state
//   redirect_valid  in  1       taken branch or resolved JR
//   redirect_pc     in  ADDR_W  redirect target
//   IR_Stage1       out 32      instruction for stage 2 (NOP = 0)
//   PC_Stage1       out ADDR_W  address of IR_Stage1
//   waiting_jr      out 1       FSM is in WAIT_JR
//   fetch_count     out 32      non-bubble instructions issued, wraps
// -----------------------------------------------------------------------------
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       IR_Stage1,
  output logic [ADDR_W-1:0] PC_Stage1,
  output logic              waiting_jr,
  output logic [31:0]       fetch_count
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       ir_q;
  logic [ADDR_W-1:0] pc1_q;
  logic [31:0]       cnt_q;

  logic              is_j_s;
  logic              is_jr_s;
  logic [ADDR_W-1:0] target_s;
  logic [ADDR_W-1:0] pc_inc_d;

  fetch_predecode #(
    .ADDR_W (ADDR_W)
  ) u_predecode (
    .instr_i  (imem_data),
    .is_j_o   (is_j_s),
    .is_jr_o  (is_jr_s),
    .target_o (target_s)
  );

  // Sequential successor; natural overflow gives the modulo-2^ADDR_W wrap
  assign pc_inc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Fetch FSM with PC, IR, PC_Stage1 and issue-count registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= {ADDR_W{1'b0}};
      ir_q    <= NOP_WORD;
      pc1_q   <= {ADDR_W{1'b0}};
      cnt_q   <= 32'd0;
    end else begin
      case (state_q)
        // One settling cycle: stall and redirect are deliberately ignored
        ST_BOOT: begin
          ir_q    <= NOP_WORD;
          pc_q    <= {ADDR_W{1'b0}};
          state_q <= ST_RUN;
        end

        ST_RUN, ST_WAIT_JR: begin
          if (redirect_valid) begin
            // The word currently on imem_data is wrong-path: drop it
            pc_q    <= redirect_pc;
            ir_q    <= NOP_WORD;
            state_q <= ST_RUN;
          end else if (stall) begin
            state_q <= state_q;
          end else if (state_q == ST_RUN) begin
            ir_q  <= imem_data;
            pc1_q <= pc_q;
            cnt_q <= cnt_q + 32'd1;
            if (is_j_s) begin
              pc_q <= target_s;
            end else if (is_jr_s) begin
              // Target unknown until downstream resolves; park the PC
              state_q <= ST_WAIT_JR;
            end else begin
              pc_q <= pc_inc_d;
            end
          end else begin
            // WAIT_JR: issue bubbles until the redirect arrives
            ir_q <= NOP_WORD;
          end
        end

        default: begin
          state_q <= ST_BOOT;
          pc_q    <= {ADDR_W{1'b0}};
          ir_q    <= NOP_WORD;
        end
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign IR_Stage1   = ir_q;
  assign PC_Stage1   = pc1_q;
  assign fetch_count = cnt_q;
  assign waiting_jr  = (state_q == ST_WAIT_JR);

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam int AW    = 12;
  localparam int DEPTH = 4096;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic [31:0]   IR_Stage1;
  logic [AW-1:0] PC_Stage1;
  logic          waiting_jr;
  logic [31:0]   fetch_count;

  logic [31:0] mem [0:DEPTH-1];
  assign imem_data = mem[imem_addr];

  always #5 clock = ~clock;

  fetch_ctrl #(.ADDR_W(AW)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .IR_Stage1      (IR_Stage1),
    .PC_Stage1      (PC_Stage1),
    .waiting_jr     (waiting_jr),
    .fetch_count    (fetch_count)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0 = boot, 1 = fetching, 2 = parked behind a jr
  int          m_mode = 0;
  int          m_pc   = 0;
  logic [31:0] m_ir   = 32'h0;
  int          m_pc1  = 0;
  logic [31:0] m_cnt  = 32'h0;
  bit          m_real = 1'b0;

  function automatic logic [31:0] plain_word();
    logic [31:0] w;
    w = $urandom;
    w[31] = 1'b1;  // opcode >= 16: never a control-flow word
    return w;
  endfunction

  function automatic logic [31:0] ctl_word(input logic [4:0] op, input int tgt);
    logic [31:0] w;
    w = $urandom;
    w[31:27] = op;
    w[11:0]  = tgt[11:0];
    return w;
  endfunction

  task automatic model_step(input bit rst, input bit st, input bit rv, input int rpc);
    logic [31:0] w;
    int op;
    if (rst) begin
      m_mode = 0; m_pc = 0; m_ir = 32'h0; m_pc1 = 0; m_cnt = 32'h0; m_real = 1'b0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_pc = 0; m_ir = 32'h0; m_real = 1'b0;
    end else if (rv) begin
      m_mode = 1; m_pc = rpc % DEPTH; m_ir = 32'h0; m_real = 1'b0;
    end else if (st) begin
      // everything frozen
    end else if (m_mode == 1) begin
      w = mem[m_pc];
      op = int'(w[31:27]);
      m_ir = w; m_pc1 = m_pc; m_cnt = m_cnt + 32'd1; m_real = 1'b1;
      if (op == 1 || op == 3) m_pc = int'(w[11:0]);
      else if (op == 4) m_mode = 2;
      else m_pc = (m_pc + 1) % DEPTH;
    end else begin
      m_ir = 32'h0; m_real = 1'b0;
    end
  endtask

  // One clock: drive inputs on the falling edge, advance the model at the
  // rising edge, leave time 1 after it for sampling.
  task automatic cycle(input bit rst, input bit st, input bit rv, input int rpc);
    @(negedge clock);
    reset = rst; stall = st; redirect_valid = rv; redirect_pc = rpc[AW-1:0];
    @(posedge clock);
    model_step(rst, st, rv, rpc);
    #1;
  endtask

  task automatic restart();
    cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 1'b0, 0);  // BOOT
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b1, 33);
    n_vec++; if (IR_Stage1 !== 32'h0) begin n_err++; $display("FAIL reset_ir got %h want 00000000", IR_Stage1); end
    n_vec++; if (imem_addr !== 12'd0) begin n_err++; $display("FAIL reset_addr got %0d want 0", imem_addr); end
    n_vec++; if (PC_Stage1 !== 12'd0) begin n_err++; $display("FAIL reset_pc1 got %0d want 0", PC_Stage1); end
    n_vec++; if (fetch_count !== 32'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", fetch_count); end
    n_vec++; if (waiting_jr !== 1'b0) begin n_err++; $display("FAIL reset_wait got %b want 0", waiting_jr); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 6; i++) mem[i] = plain_word();
    cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b1, 50);  // BOOT ignores stall and redirect
    n_vec++; if (IR_Stage1 !== 32'h0) begin n_err++; $display("FAIL seq_boot_ir got %h want 00000000", IR_Stage1); end
    n_vec++; if (imem_addr !== 12'd0) begin n_err++; $display("FAIL seq_boot_addr got %0d want 0", imem_addr); end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 0);
      n_vec++; if (IR_Stage1 !== mem[i]) begin n_err++; $display("FAIL seq_ir[%0d] got %h want %h", i, IR_Stage1, mem[i]); end
      n_vec++; if (PC_Stage1 !== 12'(i)) begin n_err++; $display("FAIL seq_pc1[%0d] got %0d want %0d", i, PC_Stage1, i); end
    end
    n_vec++; if (fetch_count !== 32'd5) begin n_err++; $display("FAIL seq_cnt got %0d want 5", fetch_count); end
    n_vec++; if (imem_addr !== 12'd5) begin n_err++; $display("FAIL seq_addr got %0d want 5", imem_addr); end
  endtask

  task automatic test_jump();
    for (int i = 0; i < 3; i++) mem[i] = plain_word();
    mem[3]   = ctl_word(5'b00001, 40);
    mem[40]  = ctl_word(5'b00011, 100);
    mem[100] = plain_word();
    restart();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 1'b0, 0);
    n_vec++; if (IR_Stage1 !== mem[3]) begin n_err++; $display("FAIL j_ir got %h want %h", IR_Stage1, mem[3]); end
    n_vec++; if (imem_addr !== 12'd40) begin n_err++; $display("FAIL j_addr got %0d want 40", imem_addr); end
    cycle(1'b0, 1'b0, 1'b0, 0);
    n_vec++; if (IR_Stage1 !== mem[40]) begin n_err++; $display("FAIL j_target_ir got %h want %h", IR_Stage1, mem[40]); end
    n_vec++; if (PC_Stage1 !== 12'd40) begin n_err++; $display("FAIL j_target_pc1 got %0d want 40", PC_Stage1); end
    cycle(1'b0, 1'b0, 1'b0, 0);
    n_vec++; if (IR_Stage1 !== mem[100]) begin n_err++; $display("FAIL jal_ir got %h want %h", IR_Stage1, mem[100]); end
    n_vec++; if (PC_Stage1 !== 12'd100) begin n_err++; $display("FAIL jal_pc1 got %0d want 100", PC_Stage1); end
  endtask

  task automatic test_jr_wait();
    mem[0] = plain_word(); mem[1] = plain_word();
    mem[2] = ctl_word(5'b00100, 777);
    mem[17] = plain_word();
    restart();
    cycle(1'b0, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 1'b0, 0);
    n_vec++; if (IR_Stage1 !== mem[2]) begin n_err++; $display("FAIL jr_ir got %h want %h", IR_Stage1, mem[2]); end
    n_vec++; if (waiting_jr !== 1'b1) begin n_err++; $display("FAIL jr_wait got %b want 1", waiting_jr); end
    n_vec++; if (imem_addr !== 12'd2) begin n_err++; $display("FAIL jr_addr got %0d want 2", imem_addr); end
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 0);
      n_vec++; if (IR_Stage1 !== 32'h0) begin n_err++; $display("FAIL jr_nop[%0d] got %h want 00000000", k, IR_Stage1); end
      n_vec++; if (waiting_jr !== 1'b1) begin n_err++; $display("FAIL jr_hold[%0d] got %b want 1", k, waiting_jr); end
    end
    cycle(1'b0, 1'b0, 1'b1, 17);
    n_vec++; if (IR_Stage1 !== 32'h0) begin n_err++; $display("FAIL jr_redir_ir got %h want 00000000", IR_Stage1); end
    n_vec++; if (waiting_jr !== 1'b0) begin n_err++; $display("FAIL jr_redir_wait got %b want 0", waiting_jr); end
    n_vec++; if (imem_addr !== 12'd17) begin n_err++; $display("FAIL jr_redir_addr got %0d want 17", imem_addr); end
    cycle(1'b0, 1'b0, 1'b0, 0);
    n_vec++; if (IR_Stage1 !== mem[17]) begin n_err++; $display("FAIL jr_target_ir got %h want %h", IR_Stage1, mem[17]); end
    n_vec++; if (fetch_count !== 32'd4) begin n_err++; $display("FAIL jr_cnt got %0d want 4", fetch_count); end
  endtask

  task automatic test_stall_redirect();
    for (int i = 0; i < 4; i++) mem[i] = plain_word();
    mem[9] = plain_word();
    restart();
    cycle(1'b0, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 0);
      n_vec++; if (IR_Stage1 !== mem[1]) begin n_err++; $display("FAIL stall_ir[%0d] got %h want %h", k, IR_Stage1, mem[1]); end
      n_vec++; if (imem_addr !== 12'd2) begin n_err++; $display("FAIL stall_addr[%0d] got %0d want 2", k, imem_addr); end
      n_vec++; if (fetch_count !== 32'd2) begin n_err++; $display("FAIL stall_cnt[%0d] got %0d want 2", k, fetch_count); end
    end
    cycle(1'b0, 1'b1, 1'b1, 9);
    n_vec++; if (IR_Stage1 !== 32'h0) begin n_err++; $display("FAIL stredir_ir got %h want 00000000", IR_Stage1); end
    n_vec++; if (imem_addr !== 12'd9) begin n_err++; $display("FAIL stredir_addr got %0d want 9", imem_addr); end
    cycle(1'b0, 1'b0, 1'b0, 0);
    n_vec++; if (IR_Stage1 !== mem[9]) begin n_err++; $display("FAIL stredir_tgt got %h want %h", IR_Stage1, mem[9]); end
    n_vec++; if (PC_Stage1 !== 12'd9) begin n_err++; $display("FAIL stredir_pc1 got %0d want 9", PC_Stage1); end
  endtask

  task automatic test_wrap_reset();
    mem[4095] = plain_word(); mem[0] = plain_word();
    restart();
    cycle(1'b0, 1'b0, 1'b1, 4095);
    n_vec++; if (imem_addr !== 12'd4095) begin n_err++; $display("FAIL wrap_pre got %0d want 4095", imem_addr); end
    cycle(1'b0, 1'b0, 1'b0, 0);
    n_vec++; if (imem_addr !== 12'd0) begin n_err++; $display("FAIL wrap_addr got %0d want 0", imem_addr); end
    n_vec++; if (IR_Stage1 !== mem[4095]) begin n_err++; $display("FAIL wrap_ir got %h want %h", IR_Stage1, mem[4095]); end
    n_vec++; if (PC_Stage1 !== 12'd4095) begin n_err++; $display("FAIL wrap_pc1 got %0d want 4095", PC_Stage1); end
    // Park behind a jr, then reset from WAIT_JR
    mem[0] = ctl_word(5'b00100, 5);
    restart();
    cycle(1'b0, 1'b0, 1'b0, 0);
    n_vec++; if (waiting_jr !== 1'b1) begin n_err++; $display("FAIL rstw_pre got %b want 1", waiting_jr); end
    cycle(1'b1, 1'b0, 1'b0, 0);
    n_vec++; if (IR_Stage1 !== 32'h0) begin n_err++; $display("FAIL rstw_ir got %h want 00000000", IR_Stage1); end
    n_vec++; if (imem_addr !== 12'd0) begin n_err++; $display("FAIL rstw_addr got %0d want 0", imem_addr); end
    n_vec++; if (waiting_jr !== 1'b0) begin n_err++; $display("FAIL rstw_wait got %b want 0", waiting_jr); end
    n_vec++; if (fetch_count !== 32'd0) begin n_err++; $display("FAIL rstw_cnt got %0d want 0", fetch_count); end
    cycle(1'b0, 1'b0, 1'b1, 77);  // BOOT: redirect ignored
    n_vec++; if (IR_Stage1 !== 32'h0) begin n_err++; $display("FAIL rstw_boot_ir got %h want 00000000", IR_Stage1); end
    n_vec++; if (imem_addr !== 12'd0) begin n_err++; $display("FAIL rstw_boot_addr got %0d want 0", imem_addr); end
  endtask

  task automatic test_random();
    int r;
    bit rst, st, rv;
    for (int i = 0; i < DEPTH; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      mem[i] = ctl_word(5'b00001, int'($urandom_range(0, DEPTH-1)));
      else if (r == 1) mem[i] = ctl_word(5'b00011, int'($urandom_range(0, DEPTH-1)));
      else if (r == 2) mem[i] = ctl_word(5'b00100, int'($urandom_range(0, DEPTH-1)));
      else             mem[i] = plain_word();
    end
    restart();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      st  = ($urandom_range(0, 4) == 0);
      if (m_mode == 2) rv = ($urandom_range(0, 3) == 0);
      else             rv = ($urandom_range(0, 14) == 0);
      cycle(rst, st, rv, int'($urandom_range(0, DEPTH-1)));
      n_vec++; if (imem_addr !== m_pc[AW-1:0]) begin n_err++; $display("FAIL rnd_addr c%0d got %0d want %0d", c, imem_addr, m_pc); end
      n_vec++; if (IR_Stage1 !== m_ir) begin n_err++; $display("FAIL rnd_ir c%0d got %h want %h", c, IR_Stage1, m_ir); end
      n_vec++; if (fetch_count !== m_cnt) begin n_err++; $display("FAIL rnd_cnt c%0d got %0d want %0d", c, fetch_count, m_cnt); end
      n_vec++; if (waiting_jr !== (m_mode == 2)) begin n_err++; $display("FAIL rnd_wait c%0d got %b want %b", c, waiting_jr, (m_mode == 2)); end
      if (m_real) begin
        n_vec++; if (PC_Stage1 !== m_pc1[AW-1:0]) begin n_err++; $display("FAIL rnd_pc1 c%0d got %0d want %0d", c, PC_Stage1, m_pc1); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = plain_word();
    test_reset();
    test_sequential();
    test_jump();
    test_jr_wait();
    test_stall_redirect();
    test_wrap_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller at the front of the 5-stage pipeline. It owns the PC, drives the instruction-memory address and produces the stage-1 instruction register that the stage-2 decode/register-read control consumes. It predecodes fetched words to follow `j`/`jal` with no bubble and to stop fetching behind `jr` until the target resolves. It also honours downstream stalls and branch/`jr` redirects.

## Interface
Parameters:
- ADDR_W, 12, PC / imem address width; PC wraps modulo 2^ADDR_W

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- imem_addr  out  ADDR_W  fetch address, equals PC register
- imem_data  in  32  instruction at imem_addr, valid same cycle (imem read on falling edge)
- stall  in  1  downstream hazard; hold PC and IR_Stage1
- redirect_valid  in  1  branch taken or jr resolved downstream
- redirect_pc  in  ADDR_W  redirect target
- IR_Stage1  out  32  instruction handed to stage 2; NOP = 32'h0
- PC_Stage1  out  ADDR_W  address of IR_Stage1
- waiting_jr  out  1  high in WAIT_JR
- fetch_count  out  32  instructions issued (non-bubble), wraps

## Operation
- Opcode = imem_data[31:27]. Predecode: J = 00001, JAL = 00011 (target = imem_data[ADDR_W-1:0]), JR = 00100; all else sequential.
- States: BOOT, RUN, WAIT_JR.
- Reset: state <= BOOT, PC <= 0, IR_Stage1 <= 0, PC_Stage1 <= 0, fetch_count <= 0; waiting_jr = 0.
- BOOT: IR_Stage1 <= NOP, PC held at 0; next state RUN. Redirect and stall are ignored in BOOT.
- Priority in RUN and WAIT_JR, highest first: redirect_valid > stall > predecode.
- Redirect (RUN or WAIT_JR): PC <= redirect_pc, IR_Stage1 <= NOP, state <= RUN. The wrong-path word is discarded. Flushing stage 2 and later stages is not this block's job.
- Stall, no redirect: PC, IR_Stage1, PC_Stage1, fetch_count and state are all held.
- RUN, no stall, no redirect:
  - IR_Stage1 <= imem_data, PC_Stage1 <= PC, fetch_count += 1.
  - J/JAL: PC <= target.
  - JR: PC held, state <= WAIT_JR.
  - Otherwise: PC <= PC+1, wrapping from 2^ADDR_W-1 to 0.
- WAIT_JR, no stall, no redirect: IR_Stage1 <= NOP, PC held, fetch_count unchanged. The block stays in WAIT_JR until redirect_valid.
- jr forwarding into a held jr is legal: a redirect landing on another JR word is fetched in RUN and re-enters WAIT_JR.

## Timing
- Registered outputs: IR_Stage1, PC_Stage1, fetch_count, imem_addr. waiting_jr is decoded from the state register.
- Fetch-to-IR latency: 1 cycle. The word on imem_data in cycle N appears on IR_Stage1 in cycle N+1.
- j/jal: 0 bubbles. The target word is fetched in cycle N+1.
- Redirect: exactly 1 NOP on IR_Stage1, then the target word.
- jr: NOPs every cycle from the cycle after the jr appears on IR_Stage1 until the redirect is taken, plus the 1 redirect NOP.
- Reset asserted mid-operation wins over everything and gives the reset values on the next edge. The first real instruction (address 0) appears on IR_Stage1 2 cycles after reset deasserts, one of those cycles being BOOT.

## Structure
- Shared package holds:
  - opcode constants OP_J, OP_JAL, OP_JR
  - NOP word
  - state enum {BOOT, RUN, WAIT_JR}
  - ADDR_W default
- One natural sub-module, fetch_predecode: combinational, imem_data -> {is_j, is_jr, target}. It is reusable by the stage-2 control.
- The rest of the block is the state register, PC/IR registers and the counter.

## Test plan
- Sequential run: reset, then imem returns add words at 0..4 -> IR_Stage1 shows them from cycle 2 after reset; PC_Stage1 = 0..4; fetch_count = 5.
- Jump: word at 3 = J to 40 -> IR_Stage1 shows addr 3 then addr 40 back-to-back with no NOP; imem_addr = 40 the cycle after 3 is presented.
- jr wait: word at 2 = JR; redirect_valid with redirect_pc = 17 three cycles later -> waiting_jr high; NOPs on IR_Stage1 until the redirect; 1 further NOP; then the addr-17 word; fetch_count counts only real words.
- Stall vs redirect: stall held for 3 cycles -> IR_Stage1 and PC frozen. Then stall and redirect (pc = 9) in the same cycle -> redirect wins: NOP, then addr 9.
- Wrap and reset: PC at 2^ADDR_W-1 sequential -> next imem_addr = 0. Reset asserted while in WAIT_JR -> next cycle IR_Stage1 = 0, PC = 0, waiting_jr = 0, state BOOT.
